// File: rtl/lsu_rmw.sv
// lsu_rmw: byte-addressed load/store front end for the word-indexed data_mem.
// Sub-word stores run as read-modify-write. Loads are extracted and extended here.
module lsu_rmw #(
  parameter int unsigned MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [2:0]  req_nb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        oob,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [2:0]  mem_nb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LD, RMW_RD, WR} state_t;

  state_t      state, state_nxt;

  // Captured request: only the byte offset, width code and low store bytes are
  // needed after accept; the word index lives in mem_addr and a full-word store
  // value goes straight into mem_wdata.
  logic [1:0]  off_q;
  logic [2:0]  nb_q;
  logic [15:0] wdata_q;

  logic [1:0]  off;
  logic        bad_nb, bad_align, err_mis, err_oob, accept, legal;
  logic [31:0] shifted, ld_val, ins_mask, ins_data, merged;

  assign mem_nb = 3'b010;

  // Request legality decode: misalignment/illegal encoding wins over range check
  always_comb begin
    off       = req_addr[1:0];
    bad_nb    = (req_nb == 3'b011) || (req_nb[2:1] == 2'b11) || (req_wr && req_nb[2]);
    bad_align = ((req_nb[1:0] == 2'b01) && off[0]) ||
                ((req_nb == 3'b010) && (off != 2'b00));
    err_mis   = bad_nb || bad_align;
    err_oob   = !err_mis && ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    accept    = req_valid && (state == IDLE);
    legal     = accept && !err_mis && !err_oob;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and memory strobes, decoded from the state register only
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    stall     = 1'b1;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (legal) begin
          if (!req_wr)                state_nxt = LD;
          else if (req_nb == 3'b010)  state_nxt = WR;
          else                        state_nxt = RMW_RD;
        end
      end
      LD: begin
        mem_rd    = 1'b1;
        state_nxt = IDLE;
      end
      RMW_RD: begin
        mem_rd    = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        mem_wr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load extraction/extension and sub-word merge into the word just read
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (nb_q)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_val = {24'h0, shifted[7:0]};
      3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_val = {16'h0, shifted[15:0]};
      default: ld_val = mem_rdata;
    endcase
    ins_mask = (nb_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
    ins_data = {16'h0, wdata_q} << {off_q, 3'b000};
    merged   = (mem_rdata & ~ins_mask) | (ins_data & ins_mask);
  end

  // Datapath registers: captured request, memory port, response and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q      <= '0;
      nb_q       <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      misalign   <= 1'b0;
      oob        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      misalign   <= accept && err_mis;
      oob        <= accept && err_oob;
      if (legal) begin
        off_q    <= req_addr[1:0];
        nb_q     <= req_nb;
        wdata_q  <= req_wdata[15:0];
        mem_addr <= {2'b00, req_addr[31:2]};
        if (req_wr && (req_nb == 3'b010)) mem_wdata <= req_wdata;
      end
      if (state == LD) begin
        resp_valid <= 1'b1;
        resp_rdata <= ld_val;
      end
      if (state == RMW_RD) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: byte-array reference model with per-cycle expectation table.
module tb_lsu_rmw;
  localparam int unsigned MEM_WORDS = 101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [2:0]  req_nb = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, stall, resp_valid, misalign, oob, mem_wr, mem_rd;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_nb;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  lsu_rmw #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_nb(req_nb),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign), .oob(oob),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_nb(mem_nb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // data_mem stand-in: combinational read, write while mem_wr is high
  logic dmem_init = 1'b1;
  logic [31:0] dmem [0:MEM_WORDS-1];
  always_comb mem_rdata = (mem_addr < MEM_WORDS) ? dmem[mem_addr[6:0]] : '0;
  always @(posedge clk) begin
    if (dmem_init) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) dmem[i] <= seed_word(i);
    end else if (mem_wr && mem_addr < MEM_WORDS) begin
      dmem[mem_addr[6:0]] <= mem_wdata;
    end
  end

  // Reference: memory as bytes, expected outputs per absolute cycle
  logic [7:0] rb [0:4*MEM_WORDS-1];

  typedef struct packed {
    logic        stall, rd, wr, rv, mis, oob, ca, cw, cr;
    logic [31:0] addr, wdata, rdata;
  } exp_t;
  exp_t exp_tab [int];

  function automatic exp_t get_exp(int c);
    return exp_tab.exists(c) ? exp_tab[c] : '0;
  endfunction

  function automatic exp_t rst_rec();
    exp_t e;
    e = '0;
    e.ca = 1'b1; e.cw = 1'b1; e.cr = 1'b1;
    return e;
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endfunction

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: every cycle, DUT outputs against the expectation table
  always @(negedge clk) begin
    exp_t e;
    e = get_exp(cyc);
    chk1("stall", stall, e.stall);
    chk1("req_ready", req_ready, !e.stall);
    chk1("mem_rd", mem_rd, e.rd);
    chk1("mem_wr", mem_wr, e.wr);
    chk1("resp_valid", resp_valid, e.rv);
    chk1("misalign", misalign, e.mis);
    chk1("oob", oob, e.oob);
    chk32("mem_nb", {29'b0, mem_nb}, 32'd2);
    if (e.ca) chk32("mem_addr", mem_addr, e.addr);
    if (e.cw) chk32("mem_wdata", mem_wdata, e.wdata);
    if (e.cr) chk32("resp_rdata", resp_rdata, e.rdata);
  end

  // Present one request in the current cycle, predict its effects, hold garbage while busy
  task automatic op(input logic wr, input logic [2:0] nb, input logic [31:0] addr,
                    input logic [31:0] wdata, output logic [31:0] pred, output int kind);
    int n, w, k, base;
    logic [31:0] idx, v;
    exp_t e;
    n = cyc;
    req_valid = 1'b1; req_wr = wr; req_nb = nb; req_addr = addr; req_wdata = wdata;
    case (nb)
      3'd0, 3'd4: w = 1;
      3'd1, 3'd5: w = 2;
      3'd2:       w = 4;
      default:    w = 0;
    endcase
    idx  = addr >> 2;
    pred = '0;
    if (w == 0 || (wr && nb[2]) || (addr % w) != 0) begin
      kind = 1; k = 1;
      e = get_exp(n + 1); e.mis = 1'b1; exp_tab[n + 1] = e;
    end else if (idx >= MEM_WORDS) begin
      kind = 2; k = 1;
      e = get_exp(n + 1); e.oob = 1'b1; exp_tab[n + 1] = e;
    end else if (!wr) begin
      kind = 0; k = 2;
      v = '0;
      for (int i = 0; i < w; i++) v |= 32'(rb[int'(addr) + i]) << (8 * i);
      if (!nb[2] && w < 4 && v[8 * w - 1]) v |= 32'hFFFF_FFFF << (8 * w);
      pred = v;
      e = get_exp(n + 1); e.stall = 1'b1; e.rd = 1'b1; e.ca = 1'b1; e.addr = idx;
      exp_tab[n + 1] = e;
      e = get_exp(n + 2); e.rv = 1'b1; e.cr = 1'b1; e.rdata = v;
      exp_tab[n + 2] = e;
    end else begin
      kind = 0;
      for (int i = 0; i < w; i++) rb[int'(addr) + i] = 8'(wdata >> (8 * i));
      base = int'(idx) * 4;
      pred = {rb[base + 3], rb[base + 2], rb[base + 1], rb[base]};
      if (w == 4) begin
        k = 2;
        e = get_exp(n + 1); e.stall = 1'b1; e.wr = 1'b1; e.ca = 1'b1; e.addr = idx;
        e.cw = 1'b1; e.wdata = pred; exp_tab[n + 1] = e;
      end else begin
        k = 3;
        e = get_exp(n + 1); e.stall = 1'b1; e.rd = 1'b1; e.ca = 1'b1; e.addr = idx;
        exp_tab[n + 1] = e;
        e = get_exp(n + 2); e.stall = 1'b1; e.wr = 1'b1; e.ca = 1'b1; e.addr = idx;
        e.cw = 1'b1; e.wdata = pred; exp_tab[n + 2] = e;
      end
    end
    @(posedge clk); #2;
    for (int j = 1; j < k; j++) begin
      req_wr = 1'($urandom); req_nb = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
  endtask

  // sb 0x00 @0x28, reset asserted while the read half of the RMW is in flight
  task automatic reset_abort();
    int n;
    n = cyc;
    req_valid = 1'b1; req_wr = 1'b1; req_nb = 3'b000; req_addr = 32'h28; req_wdata = '0;
    for (int c = n + 1; c <= n + 3; c++) exp_tab[c] = rst_rec();
    @(posedge clk); #2;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] p;
    int          kd;
    logic        rw;
    logic [2:0]  rnb;
    logic [31:0] ra;
    for (int i = 0; i < int'(MEM_WORDS); i++)
      for (int b = 0; b < 4; b++) rb[4 * i + b] = 8'(seed_word(i) >> (8 * b));
    for (int c = 0; c <= 2; c++) exp_tab[c] = rst_rec();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0; dmem_init = 1'b0;

    op(1'b1, 3'b010, 32'h28, 32'h1122_3344, p, kd); chk32("pin_sw", p, 32'h1122_3344);
    op(1'b0, 3'b010, 32'h28, 32'h0, p, kd);         chk32("pin_lw", p, 32'h1122_3344);
    op(1'b1, 3'b000, 32'h29, 32'h0000_00AB, p, kd); chk32("pin_sb", p, 32'h1122_AB44);
    op(1'b0, 3'b000, 32'h29, 32'h0, p, kd);         chk32("pin_lb", p, 32'hFFFF_FFAB);
    op(1'b0, 3'b100, 32'h29, 32'h0, p, kd);         chk32("pin_lbu", p, 32'h0000_00AB);
    op(1'b0, 3'b001, 32'h2A, 32'h0, p, kd);         chk32("pin_lh", p, 32'h0000_1122);
    reset_abort();
    op(1'b0, 3'b010, 32'h28, 32'h0, p, kd);         chk32("pin_lw_rst", p, 32'h1122_AB44);
    op(1'b1, 3'b001, 32'h2A, 32'h0000_8001, p, kd); chk32("pin_sh", p, 32'h8001_AB44);
    op(1'b0, 3'b001, 32'h2A, 32'h0, p, kd);         chk32("pin_lh2", p, 32'hFFFF_8001);
    op(1'b0, 3'b101, 32'h2A, 32'h0, p, kd);         chk32("pin_lhu", p, 32'h0000_8001);
    op(1'b0, 3'b010, 32'h2A, 32'h0, p, kd);         chk32("pin_mis_lw", 32'(kd), 32'd1);
    op(1'b1, 3'b001, 32'h29, 32'h0, p, kd);         chk32("pin_mis_sh", 32'(kd), 32'd1);
    op(1'b0, 3'b011, 32'h28, 32'h0, p, kd);         chk32("pin_ill_nb", 32'(kd), 32'd1);
    op(1'b1, 3'b010, 32'h190, 32'hCAFE_F00D, p, kd); chk32("pin_sw_w100", 32'(kd), 32'd0);
    op(1'b0, 3'b010, 32'h194, 32'h0, p, kd);        chk32("pin_oob", 32'(kd), 32'd2);
    op(1'b0, 3'b010, 32'h190, 32'h0, p, kd);        chk32("pin_lw_w100", p, 32'hCAFE_F00D);
    op(1'b1, 3'b100, 32'h28, 32'h0, p, kd);         chk32("pin_ill_sbu", 32'(kd), 32'd1);
    op(1'b0, 3'b010, 32'h1000_0000, 32'h0, p, kd);  chk32("pin_oob_far", 32'(kd), 32'd2);
    op(1'b1, 3'b001, 32'h1000_0001, 32'h0, p, kd);  chk32("pin_both", 32'(kd), 32'd1);

    for (int t = 0; t < 400; t++) begin
      rw = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       rnb = 3'($urandom);
        1, 2:    rnb = 3'b000;
        3:       rnb = 3'b100;
        4, 5:    rnb = 3'b001;
        6:       rnb = 3'b101;
        default: rnb = 3'b010;
      endcase
      if ($urandom_range(0, 19) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, 4 * MEM_WORDS + 15));
      if ($urandom_range(0, 1) == 1) ra = ra & ~32'h3;
      op(rw, rnb, ra, $urandom, p, kd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit that sits directly upstream of `data_mem` in the MEM stage. It takes byte-addressed memory requests from the EX/MEM pipeline register and converts them to the word-indexed `data_mem` port. Sub-word stores are done as a read-modify-write sequence, so neighbouring bytes are never clobbered. Loads are byte/half extracted and sign- or zero-extended here, and the block stalls the pipeline while a sequence is in flight.

## Interface
- `MEM_WORDS`, 101: number of 32-bit words in `data_mem`; word index >= `MEM_WORDS` is out of range.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  EX/MEM holds a memory op.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_nb`  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (RISC-V funct3).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (low bytes used for b/h).
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`.
- `stall`  out  1  freeze upstream pipeline.
- `resp_valid`  out  1  one-cycle pulse, load data valid.
- `resp_rdata`  out  32  extended load result.
- `misalign`  out  1  one-cycle pulse, misaligned or illegal request dropped.
- `oob`  out  1  one-cycle pulse, out-of-range request dropped.
- `mem_wr`, `mem_rd`  out  1  to `data_mem`.
- `mem_nb`  out  3  constant 3'b010. Always full-word access.
- `mem_addr`  out  32  word index `{2'b00, addr[31:2]}`.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  combinational read data from `data_mem`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - LD: `mem_rd`=1.
  - RMW_RD: `mem_rd`=1.
  - WR: `mem_wr`=1.
- `stall` = (state != IDLE). `mem_wr`/`mem_rd` decode only from the state register, never from request inputs.
- IDLE accept: capture addr, wdata, nb and wr into registers. Let o = addr[1:0].
  - Misaligned: h/hu with o[0]=1, or w with o!=0.
  - Illegal: nb in {011, 110, 111}, or a store with nb in {100, 101}.
  - Misaligned or illegal requests pulse `misalign` and stay in IDLE, with no memory access.
  - If the request is otherwise legal but its word index >= `MEM_WORDS`, pulse `oob` and stay in IDLE.
  - If both conditions hold, only `misalign` pulses.
  - Legal load → LD. Store word → WR (`mem_wdata`=wdata). Store b/h → RMW_RD.
- LD: register `mem_rdata`, extract, then → IDLE with `resp_valid`=1.
  - b/bu: byte at bits [8o+7:8o].
  - h/hu: half at bits [8o+15:8o], o ∈ {0,2}.
  - b and h sign-extend; bu and hu zero-extend.
- RMW_RD: merge register = `mem_rdata` with new bytes inserted, then → WR.
  - sb: replace byte o with wdata[7:0].
  - sh: replace half at o with wdata[15:0].
- WR: single cycle, then → IDLE. Stores never produce `resp_valid`.
- Requests presented while busy are not accepted. The requester holds them until `req_ready`.
- `resp_valid` and a new accept may coincide in the same IDLE cycle.

## Timing
- Accept at cycle N.
  - Load: LD at N+1; `resp_valid`/`resp_rdata` registered at N+2.
  - Store word: WR at N+1; ready again at N+2.
  - Sub-word store: RMW_RD at N+1, WR at N+2, ready at N+3.
  - Error: `misalign`/`oob` pulse at N+1, state stays IDLE, `req_ready` stays 1.
- `mem_addr`/`mem_wdata` are registered and held stable for the whole cycle `mem_wr`=1, because `data_mem` writes on level.
- Reset values: state IDLE. `req_ready`=1, `mem_nb`=3'b010. All other outputs 0.
- Reset mid-operation aborts immediately (asynchronous):
  - `mem_wr` drops the same instant.
  - A reset during RMW_RD or LD causes no write and no `resp_valid`.
  - A reset during WR truncates the write.

## Test plan
- sw 0x11223344 @0x28 → at N+1 `mem_wr`=1, `mem_addr`=10, `mem_wdata`=0x11223344. Then lw @0x28 → `resp_rdata`=0x11223344 at N+2.
- sb 0xAB @0x29 → RMW_RD reads 0x11223344; WR writes 0x1122AB44 at N+2; `stall` high for exactly 2 cycles.
- lb @0x29 → 0xFFFFFFAB. lbu @0x29 → 0x000000AB. lh @0x2A → 0x00001122. sh 0x8001 @0x2A then lh @0x2A → 0xFFFF8001, lhu @0x2A → 0x00008001.
- lw @0x2A, sh @0x29, and nb=011 each → `misalign` pulse at N+1; `mem_wr`/`mem_rd` never asserted; `req_ready` stays 1.
- lw @0x194 (word 101, `MEM_WORDS`=101) → `oob` pulse; no memory access. lw @0x190 (word 100) → normal read.
- Assert `rst` during RMW_RD of sb 0x00 @0x28 → `mem_wr` stays 0, all outputs at reset values. lw @0x28 after release → 0x1122AB44.
